// File: rtl/r_change_pkg.sv
// Shared register-map helpers, CTRL/STATUS bit positions and the commit FSM state type.
package r_change_pkg;

  localparam int CTRL_COMMIT_BIT = 0;
  localparam int CTRL_AUTO_BIT   = 1;
  localparam int STATUS_PEND_BIT = 0;
  localparam int STATUS_CNT_LSB  = 8;
  localparam int STATUS_CNT_W    = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_e;

  // Control registers sit directly above the per-channel shadow words.
  function automatic int ctrl_offset(input int nch);
    return nch;
  endfunction

  function automatic int status_offset(input int nch);
    return nch + 1;
  endfunction

endpackage

// File: rtl/r_change_chan.sv
// One channel: host-written shadow value plus the active copy that is loaded on transfer.
module r_change_chan #(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_dat_i,
  input  logic             xfer_i,
  output logic [WIDTH-1:0] shadow_o,
  output logic [WIDTH-1:0] active_o
);

  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] active_q;

  // Transfer samples the pre-write shadow, so a coincident host write waits for the next commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      if (wr_en_i) shadow_q <= wr_dat_i;
      if (xfer_i)  active_q <= shadow_q;
    end
  end

  assign shadow_o = shadow_q;
  assign active_o = active_q;

endmodule

// File: rtl/r_change_bank.sv
// Avalon-MM bank of double-buffered channel values, committed immediately or on the next line_sync.
module r_change_bank
  import r_change_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int WIDTH = 26,
  parameter int AW    = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [AW-1:0]        avs_s0_address,
  input  logic                 avs_s0_read,
  input  logic                 avs_s0_write,
  input  logic [31:0]          avs_s0_writedata,
  output logic [31:0]          avs_s0_readdata,
  output logic                 avs_s0_readdatavalid,
  input  logic                 line_sync,
  output logic [NCH*WIDTH-1:0] r_change_on_off,
  output logic                 apply_pulse
);

  localparam logic [AW-1:0] CTRL_A = AW'(ctrl_offset(NCH));
  localparam logic [AW-1:0] STAT_A = AW'(status_offset(NCH));

  logic [WIDTH-1:0] shadow_w [NCH];
  logic [WIDTH-1:0] active_w [NCH];

  state_e                  state_q, state_d;
  logic                    auto_q, auto_d;
  logic                    pending_q, pending_d;
  logic                    apply_q;
  logic [STATUS_CNT_W-1:0] cnt_q;
  logic [31:0]             rdata_q, rdata_d;
  logic                    rvld_q;

  logic ctrl_wr, commit_wr, shadow_wr, xfer;
  logic unused_wdata;

  assign ctrl_wr   = avs_s0_write && (avs_s0_address == CTRL_A);
  assign commit_wr = ctrl_wr && avs_s0_writedata[CTRL_COMMIT_BIT];
  assign shadow_wr = avs_s0_write && (avs_s0_address < AW'(NCH));
  assign unused_wdata = ^avs_s0_writedata;

  // The AUTO value being written decides whether this COMMIT fires now or arms.
  always_comb begin
    state_d = state_q;
    auto_d  = auto_q;
    xfer    = 1'b0;
    if (ctrl_wr) auto_d = avs_s0_writedata[CTRL_AUTO_BIT];
    unique case (state_q)
      ST_IDLE: begin
        if (commit_wr) begin
          if (auto_d) state_d = ST_ARMED;
          else        xfer    = 1'b1;
        end
      end
      ST_ARMED: begin
        if (!auto_d) begin
          state_d = ST_IDLE;
          xfer    = commit_wr;
        end else if (line_sync) begin
          xfer    = 1'b1;
          state_d = commit_wr ? ST_ARMED : ST_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    pending_d = pending_q;
    if (xfer)      pending_d = 1'b0;
    if (shadow_wr) pending_d = 1'b1;
  end

  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (avs_s0_address == AW'(i)) rdata_d = 32'(shadow_w[i]);
    end
    if (avs_s0_address == CTRL_A) rdata_d[CTRL_AUTO_BIT] = auto_q;
    if (avs_s0_address == STAT_A) begin
      rdata_d[STATUS_PEND_BIT]                   = pending_q;
      rdata_d[STATUS_CNT_LSB +: STATUS_CNT_W]    = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      auto_q    <= 1'b0;
      pending_q <= 1'b0;
      apply_q   <= 1'b0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      rvld_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      auto_q    <= auto_d;
      pending_q <= pending_d;
      apply_q   <= xfer;
      if (xfer) cnt_q <= cnt_q + 1'b1;
      rvld_q    <= avs_s0_read;
      if (avs_s0_read) rdata_q <= rdata_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    r_change_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .wr_en_i  (shadow_wr && (avs_s0_address == AW'(g))),
      .wr_dat_i (avs_s0_writedata[WIDTH-1:0]),
      .xfer_i   (xfer),
      .shadow_o (shadow_w[g]),
      .active_o (active_w[g])
    );
    assign r_change_on_off[g*WIDTH +: WIDTH] = active_w[g];
  end

  assign avs_s0_readdata      = rdata_q;
  assign avs_s0_readdatavalid = rvld_q;
  assign apply_pulse          = apply_q;

endmodule
